// File: rtl/sub_16bit_seq.sv
// Digit-serial subtractor: D = A - B - Bin, DIGIT bits per clock with a registered
// borrow between digits. Operands and results move on valid/ready handshakes.
module sub_16bit_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             Z
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_d;
    logic [CW-1:0]      r_cnt;
    logic               r_carry;
    logic               r_bout;
    logic               r_v;
    logic               r_z;

    logic [DIGIT-1:0]   w_a_dig [NDIG];
    logic [DIGIT-1:0]   w_b_dig [NDIG];
    logic [DIGIT-1:0]   w_a_cur;
    logic [DIGIT-1:0]   w_b_cur;
    logic [DIGIT:0]     w_sum;
    logic [WIDTH-1:0]   w_d_next;
    logic               w_last;
    logic               w_accept;
    logic               w_release;

    // Slice the latched operands into digits; the counter picks the active one.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
        assign w_a_dig[gi] = r_a[gi*DIGIT +: DIGIT];
        assign w_b_dig[gi] = r_b[gi*DIGIT +: DIGIT];
        assign w_d_next[gi*DIGIT +: DIGIT] =
            (r_cnt == CW'(gi)) ? w_sum[DIGIT-1:0] : r_d[gi*DIGIT +: DIGIT];
    end

    assign w_a_cur   = w_a_dig[r_cnt];
    assign w_b_cur   = w_b_dig[r_cnt];
    // Subtraction as A + ~B + carry, carry being the inverted borrow.
    assign w_sum     = {1'b0, w_a_cur} + {1'b0, ~w_b_cur} + {{DIGIT{1'b0}}, r_carry};
    assign w_last    = (r_cnt == CW'(NDIG - 1));
    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_release = (r_state == S_DONE) && out_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_BUSY;
            S_BUSY:  if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_bout  <= 1'b0;
            r_v     <= 1'b0;
            r_z     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_cnt   <= '0;
            r_carry <= ~Bin;
        end else if (r_state == S_BUSY) begin
            r_d     <= w_d_next;
            r_carry <= w_sum[DIGIT];
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            // Flags are taken from the fully assembled difference on the final digit.
            if (w_last) begin
                r_bout <= ~w_sum[DIGIT];
                r_v    <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_d_next[WIDTH-1] ^ r_a[WIDTH-1]);
                r_z    <= (w_d_next == '0);
            end
        end else if (w_release) begin
            r_cnt <= '0;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign D         = r_d;
    assign Bout      = r_bout;
    assign V         = r_v;
    assign Z         = r_z;

endmodule

// File: tb/tb_sub_16bit_seq.sv
// Directed bench for sub_16bit_seq: hand-computed vectors, handshake holds and
// mid-operation reset, each comparison an immediate assertion.
module tb_sub_16bit_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] D;
    logic        Bout;
    logic        V;
    logic        Z;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sub_16bit_seq #(.WIDTH(16), .DIGIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .V         (V),
        .Z         (Z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Accept one operation, measure latency, check result, then release it.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic bin, input logic [15:0] exp_d, input logic exp_bout,
                          input logic exp_v, input logic exp_z);
        int lat;
        @(negedge clk);
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        A = ~a; B = ~b; Bin = ~bin;
        check({tag, "_busy_no_valid"}, {31'd0, out_valid}, 32'd0);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        check({tag, "_latency"}, lat, 32'd4);
        check({tag, "_D"}, {16'd0, D}, {16'd0, exp_d});
        check({tag, "_flags"}, {29'd0, Bout, V, Z}, {29'd0, exp_bout, exp_v, exp_z});
        $display("op %s: A=%04h B=%04h Bin=%0b -> D=%04h Bout=%0b V=%0b Z=%0b lat=%0d",
                 tag, a, b, bin, D, Bout, V, Z, lat);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        logic [15:0] held_d;
        logic [2:0]  held_f;
        int          seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = 16'h0; B = 16'h0; Bin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hs", {30'd0, in_ready, out_valid}, 32'b10);
        check("reset_D", {16'd0, D}, 32'd0);
        check("reset_flags", {29'd0, Bout, V, Z}, 32'd0);
        rst = 1'b0;

        run_op("t1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_op("t2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("t3a", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op("t3b", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
        run_op("t4a", 16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        run_op("t4b", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("t4c", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Hold the result in DONE while a new request is offered.
        @(negedge clk);
        A = 16'h5A5A; B = 16'h0A0A; Bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        while (seen < 20 && !out_valid) begin
            @(posedge clk);
            @(negedge clk);
            seen++;
        end
        check("t5_reach_done", {31'd0, out_valid}, 32'd1);
        held_d = D;
        held_f = {Bout, V, Z};
        check("t5_D", {16'd0, held_d}, 32'h5050);
        A = 16'h1111; B = 16'h2222; Bin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("t5_hold_D", {16'd0, D}, {16'd0, held_d});
            check("t5_hold_flags", {29'd0, Bout, V, Z}, {29'd0, held_f});
            check("t5_hold_hs", {30'd0, in_ready, out_valid}, 32'b01);
            $display("hold cycle %0d: D=%04h in_ready=%0b out_valid=%0b", i, D, in_ready, out_valid);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("t5_release", {30'd0, in_ready, out_valid}, 32'b10);
        run_op("t5_next", 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0);

        // Reset on the second BUSY cycle aborts the operation.
        @(negedge clk);
        A = 16'h4321; B = 16'h1234; Bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("t6_reset_hs", {30'd0, in_ready, out_valid}, 32'b10);
        check("t6_reset_D", {16'd0, D}, 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("t6_no_valid", seen, 32'd0);
        $display("abort: out_valid cycles after reset=%0d", seen);
        run_op("t6_next", 16'hABCD, 16'h1111, 1'b0, 16'h9ABC, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
